// File: rtl/nmea_frame_ctrl_pkg.sv
// Shared encodings for the NMEA sentence framer: FSM states, completion codes
// and the ASCII delimiters that drive the framing decisions.
package nmea_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BODY    = 3'd1,
    ST_CS_HI   = 3'd2,
    ST_CS_LO   = 3'd3,
    ST_WAIT_CR = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CSUM    = 3'd1;
  localparam logic [2:0] ERR_HEX     = 3'd2;
  localparam logic [2:0] ERR_LEN     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_RESTART = 3'd5;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;

endpackage

// File: rtl/nmea_hex2nib.sv
// Combinational ASCII hex digit decoder; accepts 0-9, A-F and a-f.
module nmea_hex2nib (
  input  logic [7:0] ascii,
  output logic [3:0] nib,
  output logic       valid
);

  always_comb begin
    nib   = '0;
    valid = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nib   = ascii[3:0];
      valid = 1'b1;
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      // letters share the low nibble 1..6 in both cases
      nib   = ascii[3:0] + 4'd9;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/nmea_frame_ctrl.sv
// NMEA sentence framer: forwards body bytes between '$' and '*', checks the
// two-digit XOR checksum and reports one completion/abort code per sentence.
module nmea_frame_ctrl
  import nmea_frame_ctrl_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_MAX = 24'd520800,
  parameter logic [6:0]  MAX_LEN     = 7'd82
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic [7:0] frame_data,
  output logic       frame_valid,
  output logic       frame_sof,
  output logic       done,
  output logic       done_ok,
  output logic [2:0] err_code
);

  state_t      state;
  logic [7:0]  acc;
  logic [6:0]  len;
  logic [23:0] tmo;
  logic [7:0]  cs_rx;
  logic [3:0]  nib;
  logic        nib_ok;

  nmea_hex2nib u_hex2nib (
    .ascii (rx_data),
    .nib   (nib),
    .valid (nib_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      len         <= '0;
      tmo         <= '0;
      cs_rx       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_sof   <= 1'b0;
      done        <= 1'b0;
      done_ok     <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      frame_valid <= 1'b0;
      frame_sof   <= 1'b0;
      done        <= 1'b0;
      if (rx_flag) begin
        tmo <= '0;
        // '$' always restarts; mid-sentence it also closes the old one
        if (rx_data == ASCII_DOLLAR) begin
          if (state != ST_IDLE) begin
            done     <= 1'b1;
            done_ok  <= 1'b0;
            err_code <= ERR_RESTART;
          end
          state <= ST_BODY;
          acc   <= '0;
          len   <= '0;
        end else begin
          case (state)
            ST_BODY: begin
              if (rx_data == ASCII_STAR) begin
                state <= ST_CS_HI;
              end else if (len == MAX_LEN) begin
                done     <= 1'b1;
                done_ok  <= 1'b0;
                err_code <= ERR_LEN;
                state    <= ST_IDLE;
              end else begin
                acc         <= acc ^ rx_data;
                len         <= len + 7'd1;
                frame_data  <= rx_data;
                frame_valid <= 1'b1;
                frame_sof   <= (len == '0);
              end
            end
            ST_CS_HI, ST_CS_LO: begin
              if (nib_ok) begin
                if (state == ST_CS_HI) begin
                  cs_rx[7:4] <= nib;
                  state      <= ST_CS_LO;
                end else begin
                  cs_rx[3:0] <= nib;
                  state      <= ST_WAIT_CR;
                end
              end else begin
                done     <= 1'b1;
                done_ok  <= 1'b0;
                err_code <= ERR_HEX;
                state    <= ST_IDLE;
              end
            end
            ST_WAIT_CR: begin
              done  <= 1'b1;
              state <= ST_IDLE;
              if (rx_data == ASCII_CR && cs_rx == acc) begin
                done_ok  <= 1'b1;
                err_code <= ERR_NONE;
              end else begin
                done_ok  <= 1'b0;
                err_code <= ERR_CSUM;
              end
            end
            default: ;
          endcase
        end
      end else if (state == ST_IDLE) begin
        tmo <= '0;
      end else if (tmo == TIMEOUT_MAX - 24'd1) begin
        tmo      <= TIMEOUT_MAX;
        done     <= 1'b1;
        done_ok  <= 1'b0;
        err_code <= ERR_TIMEOUT;
        state    <= ST_IDLE;
      end else if (tmo != TIMEOUT_MAX) begin
        tmo <= tmo + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_nmea_frame_ctrl.sv
// Directed bench for nmea_frame_ctrl: byte strings in, forwarded bytes and
// completion codes collected by a monitor and compared to hand-derived values.
module tb_nmea_frame_ctrl;

  localparam int TMO = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_sof;
  logic       done;
  logic       done_ok;
  logic [2:0] err_code;

  int total;
  int bad;
  int viol;
  logic [8:0] fq[$];
  logic [3:0] dq[$];

  nmea_frame_ctrl #(
    .TIMEOUT_MAX (24'd40),
    .MAX_LEN     (7'd82)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_flag     (rx_flag),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_sof   (frame_sof),
    .done        (done),
    .done_ok     (done_ok),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fq.push_back({frame_sof, frame_data});
    if (done) dq.push_back({done_ok, err_code});
    if ((done && frame_valid) || (frame_sof && !frame_valid)) viol++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    @(negedge clk);
    rx_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int unsigned i = 0; i < $unsigned(s.len()); i++) send_byte(s[i]);
  endtask

  task automatic clear_q();
    fq.delete();
    dq.delete();
  endtask

  task automatic test_reset();
    total++;
    if (frame_data !== 8'h00 || frame_valid !== 1'b0 || frame_sof !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame got=%h/%b/%b want 00/0/0", frame_data, frame_valid, frame_sof);
    end
    total++;
    if (done !== 1'b0 || done_ok !== 1'b0 || err_code !== 3'd0) begin
      bad++;
      $display("FAIL reset_done got=%b/%b/%0d want 0/0/0", done, done_ok, err_code);
    end
  endtask

  task automatic test_good();
    clear_q();
    send_str("$AB*03\r");
    idle(3);
    total++;
    if (fq.size() !== 2 || fq[0] !== 9'h141 || fq[1] !== 9'h042) begin
      bad++;
      $display("FAIL good_frames got n=%0d %h %h want n=2 141 042", fq.size(), fq[0], fq[1]);
    end
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h8) begin
      bad++;
      $display("FAIL good_done got n=%0d %h want n=1 8", dq.size(), dq[0]);
    end
    total++;
    if (done_ok !== 1'b1 || err_code !== 3'd0 || frame_data !== 8'h42) begin
      bad++;
      $display("FAIL good_hold got=%b/%0d/%h want 1/0/42", done_ok, err_code, frame_data);
    end
  endtask

  task automatic test_bad_csum();
    clear_q();
    send_str("$AB*04\r");
    idle(3);
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h1) begin
      bad++;
      $display("FAIL bad_csum got n=%0d %h want n=1 1", dq.size(), dq[0]);
    end
    clear_q();
    send_str("$AB*03X");
    idle(3);
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h1) begin
      bad++;
      $display("FAIL wait_cr_other got n=%0d %h want n=1 1", dq.size(), dq[0]);
    end
  endtask

  task automatic test_hex();
    clear_q();
    send_str("$AB*0");
    rx_data = "G";
    rx_flag = 1'b1;
    @(negedge clk);
    rx_flag = 1'b0;
    total++;
    if (done !== 1'b1 || err_code !== 3'd2 || done_ok !== 1'b0) begin
      bad++;
      $display("FAIL hex_err got=%b/%0d/%b want 1/2/0", done, err_code, done_ok);
    end
    idle(2);
    send_str("\r");
    idle(2);
    total++;
    if (dq.size() !== 1) begin
      bad++;
      $display("FAIL hex_idle got n=%0d want n=1", dq.size());
    end
    clear_q();
    send_str("$Z*5a\r");
    idle(3);
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h8 || fq.size() !== 1 || fq[0] !== 9'h15A) begin
      bad++;
      $display("FAIL hex_lower got n=%0d %h fn=%0d %h want 1 8 1 15a", dq.size(), dq[0], fq.size(), fq[0]);
    end
  endtask

  task automatic test_timeout();
    clear_q();
    send_str("$A");
    idle(TMO - 2);
    send_str("*41\r");
    idle(3);
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h8) begin
      bad++;
      $display("FAIL tmo_edge got n=%0d %h want n=1 8", dq.size(), dq[0]);
    end
    clear_q();
    send_str("$A");
    idle(TMO - 2);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL tmo_early got=%b want 0", done);
    end
    idle(1);
    total++;
    if (done !== 1'b1 || err_code !== 3'd4) begin
      bad++;
      $display("FAIL tmo_fire got=%b/%0d want 1/4", done, err_code);
    end
    idle(TMO + 5);
    send_str("$B*42\r");
    idle(3);
    total++;
    if (dq.size() !== 2 || dq[0] !== 4'h4 || dq[1] !== 4'h8) begin
      bad++;
      $display("FAIL tmo_after got n=%0d %h %h want n=2 4 8", dq.size(), dq[0], dq[1]);
    end
  endtask

  task automatic test_length();
    int sofs;
    clear_q();
    send_byte(8'h24);
    for (int unsigned i = 0; i < 83; i++) send_byte(8'h41);
    idle(3);
    sofs = 0;
    foreach (fq[i]) if (fq[i][8]) sofs++;
    total++;
    if (fq.size() !== 82 || sofs !== 1 || fq[0] !== 9'h141) begin
      bad++;
      $display("FAIL len_over_frames got n=%0d sof=%0d want n=82 sof=1", fq.size(), sofs);
    end
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h3) begin
      bad++;
      $display("FAIL len_over_done got n=%0d %h want n=1 3", dq.size(), dq[0]);
    end
    clear_q();
    send_byte(8'h24);
    for (int unsigned i = 0; i < 82; i++) send_byte(8'h41);
    send_str("*00\r");
    idle(3);
    total++;
    if (fq.size() !== 82 || dq.size() !== 1 || dq[0] !== 4'h8) begin
      bad++;
      $display("FAIL len_max got n=%0d dn=%0d %h want 82 1 8", fq.size(), dq.size(), dq[0]);
    end
  endtask

  task automatic test_restart();
    clear_q();
    send_str("$AB$C*43\r");
    idle(3);
    total++;
    if (fq.size() !== 3 || fq[0] !== 9'h141 || fq[1] !== 9'h042 || fq[2] !== 9'h143) begin
      bad++;
      $display("FAIL restart_frames got n=%0d %h %h %h want 3 141 042 143", fq.size(), fq[0], fq[1], fq[2]);
    end
    total++;
    if (dq.size() !== 2 || dq[0] !== 4'h5 || dq[1] !== 4'h8) begin
      bad++;
      $display("FAIL restart_done got n=%0d %h %h want 2 5 8", dq.size(), dq[0], dq[1]);
    end
  endtask

  task automatic test_back_to_back();
    string s;
    clear_q();
    s = "$AB*03\r$C*44\r";
    for (int unsigned i = 0; i < $unsigned(s.len()); i++) begin
      rx_data = s[i];
      rx_flag = 1'b1;
      @(negedge clk);
    end
    rx_flag = 1'b0;
    idle(3);
    total++;
    if (fq.size() !== 3 || fq[1] !== 9'h042 || fq[2] !== 9'h143) begin
      bad++;
      $display("FAIL b2b_frames got n=%0d %h %h want 3 042 143", fq.size(), fq[1], fq[2]);
    end
    total++;
    if (dq.size() !== 2 || dq[0] !== 4'h8 || dq[1] !== 4'h1) begin
      bad++;
      $display("FAIL b2b_done got n=%0d %h %h want 2 8 1", dq.size(), dq[0], dq[1]);
    end
  endtask

  task automatic test_midreset();
    send_str("$AB");
    idle(1);
    clear_q();
    rst_n = 1'b0;
    #1;
    total++;
    if (frame_data !== 8'h00 || done !== 1'b0 || done_ok !== 1'b0 || err_code !== 3'd0) begin
      bad++;
      $display("FAIL midreset_out got=%h/%b/%b/%0d want 00/0/0/0", frame_data, done, done_ok, err_code);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_str("C*43\r");
    idle(3);
    total++;
    if (fq.size() !== 0 || dq.size() !== 0) begin
      bad++;
      $display("FAIL midreset_ignore got fn=%0d dn=%0d want 0 0", fq.size(), dq.size());
    end
    send_str("$C*43\r");
    idle(3);
    total++;
    if (dq.size() !== 1 || dq[0] !== 4'h8 || fq.size() !== 1 || fq[0] !== 9'h143) begin
      bad++;
      $display("FAIL midreset_next got dn=%0d %h fn=%0d want 1 8 1", dq.size(), dq[0], fq.size());
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    viol    = 0;
    rst_n   = 1'b0;
    rx_flag = 1'b0;
    rx_data = 8'h00;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_good();
    test_bad_csum();
    test_hex();
    test_timeout();
    test_length();
    test_restart();
    test_back_to_back();
    test_midreset();
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL pulse_rules got=%0d want 0", viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
